count_load_ctrl: RTL and testbench
==================================

// Module: count_load_ctrl
// PURPOSE
//  Sequencer for the counter + 13-bit register datapath: runs one burst of LEN
//  data beats, loading the register once per accepted beat.
//  Steps the counter as the beat index, then presents a result handshake.
//  Sits between a streaming source, the counter/register pair and a consumer.
//  Owns all enables/clears of the datapath; the datapath has no other master.
// PARAMETERS
//  CNT_W   6   counter width (counter with n=5); max burst 2**CNT_W-1 beats
//  DATA_W  13  register width; used only for package consistency checks
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-low reset (reset==0 resets)
//  start      in   1      1-cycle request to begin a burst; sampled in IDLE only
//  len        in   CNT_W  burst length in beats, captured on accepted start
//  abort      in   1      cancel the current burst, any state
//  pause      in   1      stall beat acceptance while 1
//  cnt_q      in   CNT_W  current counter value from the datapath
//  src_valid  in   1      source has a beat on the register input
//  src_ready  out  1      controller accepts a beat this cycle
//  res_valid  out  1      register holds the final beat of the burst
//  res_ready  in   1      consumer takes the result
//  cnt_en     out  1      counter increment enable
//  reg_en     out  1      register load enable
//  cnt_clr    out  1      counter clear (drives counter reset), registered
//  reg_clr    out  1      register clear (drives register reset), registered
//  busy       out  1      1 in every state except IDLE
//  done       out  1      1-cycle pulse when the result handshake completes
//  err        out  1      1-cycle pulse on illegal start (len==0)
// BEHAVIOUR
//  Reset values: state=IDLE, len_q=0; cnt_clr=1, reg_clr=1 (datapath is held
//   clear during reset); all other outputs 0. Clears deassert 1st edge after reset.
//  States: IDLE, CLEAR, RUN, RESULT.
//  IDLE: start & !abort & len!=0 -> latch len_q=len, go CLEAR.
//   start & len==0 -> err pulse next cycle, stay IDLE. abort beats start.
//  CLEAR (1 cycle): cnt_clr=reg_clr=1 (flop outputs, glitch-free) -> RUN.
//  RUN: src_ready = !pause & !abort. beat = src_valid & src_ready.
//   cnt_en = reg_en = beat (combinational, same cycle); the counter increments
//   and the register loads on the following edge.
//   beat & cnt_q==len_q-1 -> RESULT (last beat; counter then equals len_q).
//   src_valid=0 or pause=1: hold, no enables.
//  RESULT: res_valid=1, src_ready=0, enables 0. Register and counter hold.
//   res_valid & res_ready -> IDLE, done=1 for exactly the transition cycle+1.
//  abort in CLEAR/RUN/RESULT: next state IDLE, cnt_clr=reg_clr pulse 1 cycle,
//   no done, no res_valid in the abort cycle; beat in the abort cycle refused.
//  start while busy: ignored (no err, len_q unchanged).
//  Width: compare cnt_q against len_q-1 in CNT_W bits; len_q>=1, so no wrap.
//  Latency: start->first src_ready = 2 cycles; last beat->res_valid = 1 cycle.
//  Reset mid-burst: immediate IDLE, clears asserted as above; no done.
// STRUCTURE
//  Package count_load_pkg: CNT_W/DATA_W defaults, state enum
//   (IDLE, CLEAR, RUN, RESULT), beat-count type logic [CNT_W-1:0].
//  Flat module: one state register, len_q, registered clear/done/err flops,
//   combinational next-state and enable logic. No sub-module.
// TESTING
//  1. reset low 3 cycles -> cnt_clr=reg_clr=1, busy=0; release -> clears 0 next.
//  2. start,len=4, src_valid=1 always -> 4 reg_en pulses, res_valid, cnt_q=4;
//     res_ready=1 -> done pulse, IDLE.
//  3. len=3, pause high on beat 2 for 5 cycles -> no enables while paused,
//     exactly 3 loads total, res_valid after 3rd beat.
//  4. start,len=0 -> err pulse, busy stays 0, no clears.
//  5. abort mid-RUN after 2 beats, len=5 -> IDLE next cycle, clear pulse,
//     no done; new start,len=1 completes normally.
//  6. res_ready held low 10 cycles -> res_valid stays 1, start ignored, reg stable.

Source files
------------

// File: rtl/count_load_pkg.sv
// rtl/count_load_pkg.sv - shared widths, state encoding and beat-count type for the burst sequencer
package count_load_pkg;

  localparam int CNT_W  = 6;
  localparam int DATA_W = 13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    RESULT = 2'd3
  } state_t;

  typedef logic [CNT_W-1:0] beat_cnt_t;

endpackage

// File: rtl/count_load_ctrl.sv
// rtl/count_load_ctrl.sv - burst sequencer: clears the counter/register pair, loads one
// register value per accepted beat, then holds the result until the consumer takes it
module count_load_ctrl #(
  parameter int CNT_W  = count_load_pkg::CNT_W,
  parameter int DATA_W = count_load_pkg::DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             pause,
  input  logic [CNT_W-1:0] cnt_q,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             cnt_en,
  output logic             reg_en,
  output logic             cnt_clr,
  output logic             reg_clr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  import count_load_pkg::*;

  if (DATA_W != count_load_pkg::DATA_W) begin : g_data_w_check
    $error("count_load_ctrl: DATA_W does not match the datapath register width");
  end

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] last_cnt;
  logic             go;
  logic             bad_start;
  logic             beat;
  logic             abort_busy;
  logic             clr_d;

  always_comb begin
    go         = start & ~abort & (len != '0);
    bad_start  = start & ~abort & (len == '0);
    // len_q is never 0 once a burst is running, so this cannot wrap
    last_cnt   = len_q - CNT_W'(1);
    abort_busy = abort & (state != IDLE);

    src_ready  = (state == RUN) & ~pause & ~abort;
    beat       = src_valid & src_ready;
    cnt_en     = beat;
    reg_en     = beat;
    res_valid  = (state == RESULT) & ~abort;
    busy       = (state != IDLE);

    state_d = state;
    case (state)
      IDLE:    if (go) state_d = CLEAR;
      CLEAR:   state_d = RUN;
      RUN:     if (beat && (cnt_q == last_cnt)) state_d = RESULT;
      RESULT:  if (res_valid && res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_busy) state_d = IDLE;

    // clears are flopped so the datapath resets see a clean level
    clr_d = (state_d == CLEAR) | abort_busy;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      len_q   <= '0;
      cnt_clr <= 1'b1;
      reg_clr <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      if ((state == IDLE) && go) len_q <= len;
      cnt_clr <= clr_d;
      reg_clr <= clr_d;
      done    <= res_valid & res_ready;
      err     <= (state == IDLE) & bad_start;
    end
  end

endmodule

// File: tb/tb_count_load_ctrl.sv
// tb/tb_count_load_ctrl.sv - scoreboard bench for count_load_ctrl with a behavioural counter/register datapath
module tb_count_load_ctrl;

  localparam int CNT_W  = 6;
  localparam int DATA_W = 13;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              abort;
  logic              pause;
  logic [CNT_W-1:0]  cnt_q;
  logic              src_valid;
  logic              src_ready;
  logic              res_valid;
  logic              res_ready;
  logic              cnt_en;
  logic              reg_en;
  logic              cnt_clr;
  logic              reg_clr;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] src_data;
  logic [DATA_W-1:0] reg_q;

  typedef struct { int idx; int data; } beat_t;
  typedef struct { int cnt; int data; } res_t;

  beat_t q_beat[$];
  res_t  q_res[$];
  int    q_done[$];
  int    q_err[$];

  int n_cmp   = 0;
  int n_fail  = 0;
  int n_loads = 0;
  int acc_cnt = 0;

  count_load_ctrl #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort),
    .pause(pause), .cnt_q(cnt_q), .src_valid(src_valid), .src_ready(src_ready),
    .res_valid(res_valid), .res_ready(res_ready), .cnt_en(cnt_en), .reg_en(reg_en),
    .cnt_clr(cnt_clr), .reg_clr(reg_clr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      reg_q <= '0;
    end else begin
      if (cnt_clr)     cnt_q <= '0;
      else if (cnt_en) cnt_q <= cnt_q + 1'b1;
      if (reg_clr)     reg_q <= '0;
      else if (reg_en) reg_q <= src_data;
    end
  end

  always @(posedge clk) if (reset && src_valid && src_ready) acc_cnt <= acc_cnt + 1;

  function automatic logic [DATA_W-1:0] tbl(input int i);
    int v;
    v = (i * 397 + 21) % 8192;
    return v[DATA_W-1:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (reg_en) begin
        beat_t b;
        n_loads++;
        chk("cnt_en_with_reg_en", {31'd0, cnt_en}, 1);
        if (q_beat.size() == 0) chk("unexpected_beat", {31'd0, reg_en}, 0);
        else begin
          b = q_beat.pop_front();
          chk("beat_idx", cnt_q, b.idx);
          chk("beat_data", src_data, b.data);
        end
      end
      if (res_valid && res_ready) begin
        res_t r;
        if (q_res.size() == 0) chk("unexpected_result", {31'd0, res_valid}, 0);
        else begin
          r = q_res.pop_front();
          chk("result_cnt", cnt_q, r.cnt);
          chk("result_reg", reg_q, r.data);
        end
      end
      if (done) begin
        if (q_done.size() == 0) chk("unexpected_done", {31'd0, done}, 0);
        else void'(q_done.pop_front());
      end
      if (err) begin
        if (q_err.size() == 0) chk("unexpected_err", {31'd0, err}, 0);
        else void'(q_err.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    src_data = tbl(acc_cnt);
  endtask

  task automatic expect_burst(input int l);
    int g;
    g = acc_cnt;
    for (int i = 0; i < l; i++) q_beat.push_back('{idx: i, data: int'(tbl(g + i))});
    q_res.push_back('{cnt: l, data: int'(tbl(g + l - 1))});
    q_done.push_back(1);
  endtask

  task automatic issue_start(input int l);
    start = 1'b1;
    len   = CNT_W'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_res(input int maxc);
    int k;
    k = 0;
    while (!res_valid && k < maxc) begin
      tick();
      #3;
      k++;
    end
    chk("res_valid_reached", {31'd0, res_valid}, 1);
  endtask

  task automatic wait_beats(input int target, input int maxc);
    int k;
    k = 0;
    while (acc_cnt < target && k < maxc) begin
      tick();
      k++;
    end
    chk("beats_reached", acc_cnt, target);
  endtask

  task automatic handshake();
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    #3;
    chk("done_pulse", {31'd0, done}, 1);
    chk("idle_after_done", {31'd0, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int loads0;
    logic [DATA_W-1:0] held;
    reset = 1'b0; start = 1'b0; len = '0; abort = 1'b0; pause = 1'b0;
    src_valid = 1'b0; res_ready = 1'b0; src_data = tbl(0);

    // reset held low: datapath clears asserted, controller idle
    repeat (3) tick();
    #3;
    chk("rst_cnt_clr", {31'd0, cnt_clr}, 1);
    chk("rst_reg_clr", {31'd0, reg_clr}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_src_ready", {31'd0, src_ready}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    tick();
    reset = 1'b1;
    #3;
    chk("rel_cnt_clr_held", {31'd0, cnt_clr}, 1);
    tick();
    #3;
    chk("rel_cnt_clr", {31'd0, cnt_clr}, 0);
    chk("rel_reg_clr", {31'd0, reg_clr}, 0);

    // len=4 with a source that is always valid
    src_valid = 1'b1;
    expect_burst(4);
    start = 1'b1;
    len   = 6'd4;
    #3;
    chk("t2_busy_before", {31'd0, busy}, 0);
    tick();
    start = 1'b0;
    #3;
    chk("t2_clear_busy", {31'd0, busy}, 1);
    chk("t2_clear_cnt_clr", {31'd0, cnt_clr}, 1);
    chk("t2_clear_src_ready", {31'd0, src_ready}, 0);
    tick();
    #3;
    chk("t2_first_ready", {31'd0, src_ready}, 1);
    chk("t2_cnt_start", cnt_q, 0);
    wait_res(20);
    chk("t2_cnt_final", cnt_q, 4);
    handshake();

    // len=3 with a 5-cycle pause after the first beat
    loads0 = n_loads;
    g = acc_cnt;
    expect_burst(3);
    issue_start(3);
    wait_beats(g + 1, 10);
    pause = 1'b1;
    repeat (5) begin
      #3;
      chk("t3_pause_ready", {31'd0, src_ready}, 0);
      chk("t3_pause_reg_en", {31'd0, reg_en}, 0);
      chk("t3_pause_cnt_en", {31'd0, cnt_en}, 0);
      tick();
    end
    pause = 1'b0;
    #3;
    wait_res(20);
    chk("t3_loads", n_loads - loads0, 3);
    handshake();

    // len=0 is rejected with an error pulse and no clears
    q_err.push_back(1);
    issue_start(0);
    #3;
    chk("t4_err", {31'd0, err}, 1);
    chk("t4_busy", {31'd0, busy}, 0);
    chk("t4_cnt_clr", {31'd0, cnt_clr}, 0);
    tick();
    #3;
    chk("t4_err_gone", {31'd0, err}, 0);

    // abort after two of five beats, then a normal len=1 burst
    g = acc_cnt;
    q_beat.push_back('{idx: 0, data: int'(tbl(g))});
    q_beat.push_back('{idx: 1, data: int'(tbl(g + 1))});
    issue_start(5);
    wait_beats(g + 2, 10);
    abort = 1'b1;
    #3;
    chk("t5_abort_ready", {31'd0, src_ready}, 0);
    chk("t5_abort_reg_en", {31'd0, reg_en}, 0);
    tick();
    abort = 1'b0;
    #3;
    chk("t5_idle", {31'd0, busy}, 0);
    chk("t5_cnt_clr", {31'd0, cnt_clr}, 1);
    chk("t5_reg_clr", {31'd0, reg_clr}, 1);
    chk("t5_no_done", {31'd0, done}, 0);
    tick();
    #3;
    chk("t5_clr_end", {31'd0, cnt_clr}, 0);
    chk("t5_cnt_zero", cnt_q, 0);
    chk("t5_reg_zero", reg_q, 0);
    expect_burst(1);
    issue_start(1);
    #3;
    wait_res(20);
    handshake();

    // consumer stalls for 10 cycles; a start during RESULT is ignored
    g = acc_cnt;
    expect_burst(2);
    held = tbl(g + 1);
    issue_start(2);
    #3;
    wait_res(20);
    for (int i = 0; i < 10; i++) begin
      chk("t6_res_valid", {31'd0, res_valid}, 1);
      chk("t6_reg_stable", reg_q, held);
      chk("t6_no_err", {31'd0, err}, 0);
      tick();
      if (i == 3) begin start = 1'b1; len = 6'd7; end
      if (i == 4) start = 1'b0;
      #3;
    end
    handshake();
    tick();
    #3;
    chk("t6_start_ignored", {31'd0, busy}, 0);

    // reset mid-burst drops straight to idle with clears asserted
    g = acc_cnt;
    q_beat.push_back('{idx: 0, data: int'(tbl(g))});
    issue_start(3);
    wait_beats(g + 1, 10);
    src_valid = 1'b0;
    reset = 1'b0;
    #3;
    chk("t7_busy", {31'd0, busy}, 0);
    chk("t7_cnt_clr", {31'd0, cnt_clr}, 1);
    chk("t7_reg_clr", {31'd0, reg_clr}, 1);
    tick();
    reset = 1'b1;
    tick();
    #3;
    chk("t7_clr_end", {31'd0, cnt_clr}, 0);
    chk("t7_no_done", {31'd0, done}, 0);
    tick();

    chk("left_beats", q_beat.size(), 0);
    chk("left_results", q_res.size(), 0);
    chk("left_done", q_done.size(), 0);
    chk("left_err", q_err.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
